// File: rtl/triple_port_pkg.sv
// Shared constants and response entry type for the triple-ported memory.
// The request path uses the same constants and bank-select helper.
package triple_port_pkg;

    localparam int NUM_BANKS  = 4;
    localparam int NUM_PORTS  = 3;
    localparam int TAG_W      = 2;
    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 12;
    localparam int BANK_SEL_W = 2;
    localparam int FIFO_DEPTH = 4;

    typedef struct packed {
        logic              wen;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } resp_entry_t;

    // Bank index carried in the low address bits.
    function automatic logic [BANK_SEL_W-1:0] bank_of(input logic [ADDR_W-1:0] addr);
        return addr[BANK_SEL_W-1:0];
    endfunction

endpackage

// File: rtl/resp_fifo.sv
// Per-port synchronous response FIFO. A push into a full FIFO is accepted
// only when a pop frees a slot in the same cycle; otherwise it is ignored.
import triple_port_pkg::*;

module resp_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  resp_entry_t                i_entry,
    output resp_entry_t                o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    resp_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_empty   = (r_count == {CNT_W{1'b0}});
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage, pointers (wrap modulo DEPTH) and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_entry;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bank_response_router.sv
// Return path of the triple-ported memory: picks the responding bank per lane,
// buffers each port's responses and flags collisions and overflows.
import triple_port_pkg::*;

module bank_response_router #(
    parameter int FIFO_DEPTH = triple_port_pkg::FIFO_DEPTH
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_BANKS*NUM_PORTS-1:0]         bank_resp_valid,
    input  logic [NUM_BANKS*NUM_PORTS*TAG_W-1:0]   bank_resp_tag,
    input  logic [NUM_BANKS*NUM_PORTS*DATA_W-1:0]  bank_resp_data,
    input  logic [NUM_BANKS*NUM_PORTS-1:0]         bank_resp_wen,
    output logic                                   port1_resp_valid,
    input  logic                                   port1_resp_ready,
    output logic [TAG_W-1:0]                       port1_resp_tag,
    output logic [DATA_W-1:0]                      port1_resp_data,
    output logic                                   port1_resp_wen,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]        port1_resp_count,
    output logic                                   port2_resp_valid,
    input  logic                                   port2_resp_ready,
    output logic [TAG_W-1:0]                       port2_resp_tag,
    output logic [DATA_W-1:0]                      port2_resp_data,
    output logic                                   port2_resp_wen,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]        port2_resp_count,
    output logic                                   port3_resp_valid,
    input  logic                                   port3_resp_ready,
    output logic [TAG_W-1:0]                       port3_resp_tag,
    output logic [DATA_W-1:0]                      port3_resp_data,
    output logic                                   port3_resp_wen,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]        port3_resp_count,
    input  logic                                   err_clr,
    output logic [NUM_PORTS-1:0]                   collision_err,
    output logic [NUM_PORTS-1:0]                   overflow_err
);

    localparam int CNT_W = $clog2(FIFO_DEPTH+1);

    resp_entry_t          w_sel_entry [NUM_PORTS];
    resp_entry_t          w_head      [NUM_PORTS];
    resp_entry_t          w_out       [NUM_PORTS];
    logic [CNT_W-1:0]     w_count     [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_sel_valid;
    logic [NUM_PORTS-1:0] w_collision;
    logic [NUM_PORTS-1:0] w_overflow;
    logic [NUM_PORTS-1:0] w_full;
    logic [NUM_PORTS-1:0] w_empty;
    logic [NUM_PORTS-1:0] w_pop;
    logic [NUM_PORTS-1:0] w_ready;
    logic [NUM_PORTS-1:0] r_collision_err;
    logic [NUM_PORTS-1:0] r_overflow_err;

    assign w_ready = {port3_resp_ready, port2_resp_ready, port1_resp_ready};

    // Lowest-numbered valid bank wins each lane; any later valid bank is a collision.
    always_comb begin
        w_sel_valid = {NUM_PORTS{1'b0}};
        w_collision = {NUM_PORTS{1'b0}};
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_sel_entry[p] = '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                w_collision[p] = w_collision[p] |
                                 (w_sel_valid[p] & bank_resp_valid[b*NUM_PORTS+p]);
                w_sel_entry[p] = (bank_resp_valid[b*NUM_PORTS+p] && !w_sel_valid[p]) ?
                                 {bank_resp_wen[b*NUM_PORTS+p],
                                  bank_resp_tag[(b*NUM_PORTS+p)*TAG_W +: TAG_W],
                                  bank_resp_data[(b*NUM_PORTS+p)*DATA_W +: DATA_W]} :
                                 w_sel_entry[p];
                w_sel_valid[p] = w_sel_valid[p] | bank_resp_valid[b*NUM_PORTS+p];
            end
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        assign w_pop[g]      = w_ready[g] & ~w_empty[g];
        assign w_overflow[g] = w_sel_valid[g] & w_full[g] & ~w_pop[g];
        assign w_out[g]      = w_empty[g] ? '0 : w_head[g];

        resp_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_push  (w_sel_valid[g]),
            .i_pop   (w_pop[g]),
            .i_entry (w_sel_entry[g]),
            .o_head  (w_head[g]),
            .o_full  (w_full[g]),
            .o_empty (w_empty[g]),
            .o_count (w_count[g])
        );
    end

    // Sticky error flags; a new event in the clearing cycle keeps its flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_collision_err <= {NUM_PORTS{1'b0}};
            r_overflow_err  <= {NUM_PORTS{1'b0}};
        end else if (err_clr) begin
            r_collision_err <= w_collision;
            r_overflow_err  <= w_overflow;
        end else begin
            r_collision_err <= r_collision_err | w_collision;
            r_overflow_err  <= r_overflow_err | w_overflow;
        end
    end

    assign collision_err    = r_collision_err;
    assign overflow_err     = r_overflow_err;

    assign port1_resp_valid = ~w_empty[0];
    assign port1_resp_tag   = w_out[0].tag;
    assign port1_resp_data  = w_out[0].data;
    assign port1_resp_wen   = w_out[0].wen;
    assign port1_resp_count = w_count[0];

    assign port2_resp_valid = ~w_empty[1];
    assign port2_resp_tag   = w_out[1].tag;
    assign port2_resp_data  = w_out[1].data;
    assign port2_resp_wen   = w_out[1].wen;
    assign port2_resp_count = w_count[1];

    assign port3_resp_valid = ~w_empty[2];
    assign port3_resp_tag   = w_out[2].tag;
    assign port3_resp_data  = w_out[2].data;
    assign port3_resp_wen   = w_out[2].wen;
    assign port3_resp_count = w_count[2];

endmodule

// File: tb/tb_bank_response_router.sv
// Scoreboard bench for bank_response_router: directed bank responses with
// hand-computed expectations, checked by a per-port monitor on handshakes.
import triple_port_pkg::*;

module tb_bank_response_router;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] bv;
    logic [23:0] btag;
    logic [191:0] bdata;
    logic [11:0] bwen;
    logic        rdy1, rdy2, rdy3;
    logic        v1, v2, v3, wen1, wen2, wen3;
    logic [1:0]  tag1, tag2, tag3;
    logic [15:0] dat1, dat2, dat3;
    logic [2:0]  cnt1, cnt2, cnt3;
    logic        err_clr;
    logic [2:0]  coll, ovf;

    int checks   = 0;
    int failures = 0;
    resp_entry_t sb_q [3][$];

    always #5 clk = ~clk;

    bank_response_router dut (
        .clk(clk), .rst_n(rst_n),
        .bank_resp_valid(bv), .bank_resp_tag(btag),
        .bank_resp_data(bdata), .bank_resp_wen(bwen),
        .port1_resp_valid(v1), .port1_resp_ready(rdy1), .port1_resp_tag(tag1),
        .port1_resp_data(dat1), .port1_resp_wen(wen1), .port1_resp_count(cnt1),
        .port2_resp_valid(v2), .port2_resp_ready(rdy2), .port2_resp_tag(tag2),
        .port2_resp_data(dat2), .port2_resp_wen(wen2), .port2_resp_count(cnt2),
        .port3_resp_valid(v3), .port3_resp_ready(rdy3), .port3_resp_tag(tag3),
        .port3_resp_data(dat3), .port3_resp_wen(wen3), .port3_resp_count(cnt3),
        .err_clr(err_clr), .collision_err(coll), .overflow_err(ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic mon_port(input int p, input logic v, input logic r,
                            input logic [1:0] t, input logic [15:0] d, input logic w);
        resp_entry_t e;
        if (v && r) begin
            if (sb_q[p].size() == 0) begin
                chk($sformatf("port%0d_unexpected_resp", p+1), 32'd1, 32'd0);
            end else begin
                e = sb_q[p].pop_front();
                chk($sformatf("port%0d_tag", p+1), {30'd0, t}, {30'd0, e.tag});
                chk($sformatf("port%0d_data", p+1), {16'd0, d}, {16'd0, e.data});
                chk($sformatf("port%0d_wen", p+1), {31'd0, w}, {31'd0, e.wen});
            end
        end
    endtask

    // Monitor: outputs and ready are stable at the falling edge.
    always @(negedge clk) begin
        mon_port(0, v1, rdy1, tag1, dat1, wen1);
        mon_port(1, v2, rdy2, tag2, dat2, wen2);
        mon_port(2, v3, rdy3, tag3, dat3, wen3);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_banks();
        bv = '0; btag = '0; bdata = '0; bwen = '0;
    endtask

    task automatic set_resp(input int b, input int p, input logic [1:0] t,
                            input logic [15:0] d, input logic w);
        int idx;
        idx = b*3 + p;
        bv[idx] = 1'b1;
        btag[idx*2 +: 2] = t;
        bdata[idx*16 +: 16] = d;
        bwen[idx] = w;
    endtask

    task automatic expect_resp(input int p, input logic [1:0] t,
                               input logic [15:0] d, input logic w);
        resp_entry_t e;
        e.tag = t; e.data = d; e.wen = w;
        sb_q[p].push_back(e);
    endtask

    task automatic wait_drain(input int p);
        int n;
        n = 0;
        while (sb_q[p].size() != 0 && n < 20) begin
            tick();
            n++;
        end
        chk($sformatf("port%0d_drain_left", p+1), sb_q[p].size(), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; err_clr = 1'b0;
        rdy1 = 1'b0; rdy2 = 1'b0; rdy3 = 1'b0;
        clear_banks();
        #3;
        chk("rst_valid", {29'd0, v1, v2, v3}, 32'd0);
        chk("rst_counts", {23'd0, cnt1, cnt2, cnt3}, 32'd0);
        chk("rst_data", {dat1, dat3}, 32'd0);
        chk("rst_errs", {26'd0, coll, ovf}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single read response, one-cycle latency, then masked back to zero
        rdy1 = 1'b1;
        set_resp(2, 0, 2'b01, 16'hBEEF, 1'b0);
        expect_resp(0, 2'b01, 16'hBEEF, 1'b0);
        tick();
        clear_banks();
        chk("read_valid", {31'd0, v1}, 32'd1);
        chk("read_data_now", {16'd0, dat1}, 32'h0000BEEF);
        tick();
        chk("read_valid_after", {31'd0, v1}, 32'd0);
        chk("read_data_masked", {16'd0, dat1}, 32'd0);

        // Back-pressure then overflow on port 2
        for (int i = 0; i < 5; i++) begin
            set_resp(1, 1, 2'(i), 16'h2000 + 16'(i), 1'b0);
            if (i < 4) expect_resp(1, 2'(i), 16'h2000 + 16'(i), 1'b0);
            tick();
        end
        clear_banks();
        chk("ovf_count", {29'd0, cnt2}, 32'd4);
        chk("ovf_flag", {29'd0, ovf}, 32'b010);
        chk("ovf_no_coll", {29'd0, coll}, 32'd0);
        rdy2 = 1'b1;
        wait_drain(1);
        tick();
        chk("ovf_drained_count", {29'd0, cnt2}, 32'd0);
        chk("ovf_drained_valid", {31'd0, v2}, 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("ovf_cleared", {29'd0, ovf}, 32'd0);

        // Full FIFO with simultaneous push and pop on port 3
        for (int i = 0; i < 4; i++) begin
            set_resp(0, 2, 2'(i), 16'h3000 + 16'(i), 1'b1);
            expect_resp(2, 2'(i), 16'h3000 + 16'(i), 1'b1);
            tick();
        end
        chk("full_count", {29'd0, cnt3}, 32'd4);
        set_resp(0, 2, 2'd0, 16'h3004, 1'b1);
        expect_resp(2, 2'd0, 16'h3004, 1'b1);
        rdy3 = 1'b1;
        tick();
        clear_banks();
        rdy3 = 1'b0;
        chk("fullpp_count", {29'd0, cnt3}, 32'd4);
        chk("fullpp_no_ovf", {31'd0, ovf[2]}, 32'd0);
        chk("fullpp_head", {16'd0, dat3}, 32'h00003001);
        rdy3 = 1'b1;
        wait_drain(2);

        // Collision: lowest bank wins, sticky flag, clear, set-wins
        set_resp(0, 0, 2'd2, 16'h1111, 1'b0);
        set_resp(3, 0, 2'd3, 16'h3333, 1'b0);
        expect_resp(0, 2'd2, 16'h1111, 1'b0);
        tick();
        clear_banks();
        chk("coll_flag", {29'd0, coll}, 32'b001);
        chk("coll_winner", {16'd0, dat1}, 32'h00001111);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("coll_cleared", {29'd0, coll}, 32'd0);
        err_clr = 1'b1;
        set_resp(1, 0, 2'd1, 16'h4444, 1'b0);
        set_resp(2, 0, 2'd0, 16'h5555, 1'b0);
        expect_resp(0, 2'd1, 16'h4444, 1'b0);
        tick();
        clear_banks();
        err_clr = 1'b0;
        chk("coll_set_wins", {29'd0, coll}, 32'b001);
        wait_drain(0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Independent same-cycle responses on all three ports
        set_resp(0, 0, 2'd1, 16'hA0A0, 1'b0);
        set_resp(1, 1, 2'd2, 16'hB1B1, 1'b1);
        set_resp(2, 2, 2'd3, 16'hC2C2, 1'b0);
        expect_resp(0, 2'd1, 16'hA0A0, 1'b0);
        expect_resp(1, 2'd2, 16'hB1B1, 1'b1);
        expect_resp(2, 2'd3, 16'hC2C2, 1'b0);
        tick();
        clear_banks();
        chk("par_valid", {29'd0, v1, v2, v3}, 32'b111);
        chk("par_no_errs", {26'd0, coll, ovf}, 32'd0);
        wait_drain(0);
        wait_drain(1);
        wait_drain(2);

        // Asynchronous reset with buffered responses on port 1
        rdy1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_resp(3, 0, 2'(i), 16'h6000 + 16'(i), 1'b0);
            tick();
        end
        clear_banks();
        chk("pre_rst_count", {29'd0, cnt1}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, v1}, 32'd0);
        chk("async_rst_data", {14'd0, tag1, dat1}, 32'd0);
        chk("async_rst_count", {29'd0, cnt1}, 32'd0);
        tick();
        rst_n = 1'b1;
        rdy1 = 1'b1;
        repeat (3) tick();
        chk("post_rst_valid", {31'd0, v1}, 32'd0);
        chk("post_rst_count", {29'd0, cnt1}, 32'd0);

        chk("sb_empty", sb_q[0].size() + sb_q[1].size() + sb_q[2].size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bank_response_router.md
Name: bank_response_router

Overview:
- Return path of the triple-ported memory: collects per-lane responses from the 4 banks and delivers them to the 3 requesting ports.
- The request path masks and dispatches each port's request to the bank selected by addr[1:0]. Each bank returns up to one response per port lane per cycle.
- The router selects the responding bank per port and buffers responses in a per-port FIFO with a valid/ready output handshake.
- Banks cannot be stalled, so overflow and collisions are flagged, not back-pressured.

Parameters:
- NUM_BANKS, 4, number of banks (bank b = addr[1:0]).
- NUM_PORTS, 3, number of ports/lanes per bank.
- TAG_W, 2, request tag width.
- DATA_W, 16, data width.
- FIFO_DEPTH, 4, per-port response FIFO entries; power of 2, >= 2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- bank_resp_valid  in  NUM_BANKS*NUM_PORTS  bit [b*NUM_PORTS+p]: bank b has a response on lane p.
- bank_resp_tag  in  NUM_BANKS*NUM_PORTS*TAG_W  tag per bank/lane, same indexing.
- bank_resp_data  in  NUM_BANKS*NUM_PORTS*DATA_W  read data per bank/lane; don't-care for writes.
- bank_resp_wen  in  NUM_BANKS*NUM_PORTS  1 = write acknowledge, 0 = read response.
- portN_resp_valid  out  1  (N=1..3, one set each) response available at FIFO head.
- portN_resp_ready  in  1  consumer accepts the head this cycle.
- portN_resp_tag  out  TAG_W  head tag.
- portN_resp_data  out  DATA_W  head data.
- portN_resp_wen  out  1  head wen.
- portN_resp_count  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy.
- err_clr  in  1  synchronous clear of the sticky error flags.
- collision_err  out  NUM_PORTS  sticky; more than one bank valid for the same lane in one cycle.
- overflow_err  out  NUM_PORTS  sticky; response dropped because the FIFO was full.

Behaviour:
- Reset (async assert, sync-safe release):
  - FIFO pointers and counts = 0.
  - All portN_resp_valid/tag/data/wen = 0.
  - collision_err and overflow_err = 0.
- Lane select, per port p, combinational:
  - Candidate banks are those with bank_resp_valid[b*NUM_PORTS+p] = 1; the lowest b wins.
  - Two or more candidates -> set collision_err[p] at the next edge. The winner is still pushed; losers are dropped.
- Push:
  - The selected response is written into port p's FIFO at the clock edge.
  - It is visible on portN_resp_* the following cycle; latency from bank valid to portN_resp_valid is exactly 1 cycle when the FIFO is empty.
  - No bypass path.
- Pop: on valid && ready at the edge, the head is removed and the next entry is presented the following cycle.
- Full with push and pop in the same cycle: both occur, count is unchanged, no overflow.
- Full with push and no pop: the response is dropped, overflow_err[p] is set, and FIFO contents are unchanged.
- Empty with push and ready: no pop (valid was 0); the entry is presented next cycle.
- Masking: when the FIFO is empty, portN_resp_tag/data/wen are driven to 0, never stale storage.
- Pointers: log2(FIFO_DEPTH) bits, wrap modulo depth; count is tracked separately (0..FIFO_DEPTH).
- Error flags: err_clr clears all flags at the next edge. An error event in the same cycle as err_clr leaves that flag set (set wins).
- Ordering: per-port responses are delivered in arrival order. Same-cycle responses for different ports are fully independent.
- Reset mid-operation: all buffered responses are discarded and outputs go to 0 immediately on rst_n low.

Decomposition:
- Shared package triple_port_pkg holds NUM_BANKS, NUM_PORTS, TAG_W, DATA_W, ADDR_W=12, BANK_SEL_W=2, and the response entry struct {wen, tag, data}. The request path reuses the same constants.
- Sub-module resp_fifo: one synchronous FIFO with push/pop/full/empty/count, instantiated NUM_PORTS times. Priority select, error flags and output masking live in the top.

Test Plan:
- Read response: bank 2 lane 0 valid, tag=2'b01, data=16'hBEEF, wen=0, port1_resp_ready=1 -> next cycle port1_resp_valid=1, tag=01, data=BEEF, wen=0; following cycle valid=0 and data=0.
- Backpressure and overflow: port2 ready=0, 5 consecutive pushes from bank 1 lane 1 (tags 0,1,2,3,0) -> count reaches 4; 5th dropped; overflow_err=3'b010. Then ready=1 -> tags 0,1,2,3 delivered in order.
- Full push+pop: port3 FIFO full, ready=1, push in the same cycle -> count stays 4, overflow_err[2]=0, head advances.
- Collision: banks 0 and 3 both valid on lane 0 (data 16'h1111, 16'h3333) -> port1 gets 1111 only; collision_err=3'b001. err_clr pulse -> 0. err_clr pulsed in the same cycle as a new collision -> flag stays 1.
- Parallel ports: banks 0, 1, 2 valid on lanes 0, 1, 2 in the same cycle with distinct data -> all three ports valid next cycle with the correct data; no errors.
- Async reset: rst_n low mid-stream with count=3 -> outputs 0 immediately; after release count=0 and no stale data delivered.
